huff_encoder_n: RTL and testbench
=================================

# huff_encoder_n

Parametrised Huffman code generator. It accepts NSYM (symbol, frequency) pairs over a valid/ready load port and builds the Huffman tree with one merge per cycle. It then assigns codes top-down and streams one (symbol, code, length, mask) record per symbol over a valid/ready output port. It replaces the fixed 3-symbol encoder and serves as the tree/codebook stage ahead of the bitstream packer.

## Interface
Parameters:
- NSYM, 4: symbols per block; legal range 2..16.
- SYM_W, 8: symbol width.
- FREQ_W, 4: frequency width; frequency 0 is legal.
- Derived, not overridable:
  - CODE_W = NSYM-1.
  - W_W = FREQ_W + clog2(NSYM); node weights never overflow.
  - NODES = 2*NSYM-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  load pair valid.
- in_ready  out  1  high only in LOAD.
- in_sym  in  SYM_W  symbol.
- in_freq  in  FREQ_W  frequency.
- out_valid  out  1  codebook record valid.
- out_ready  in  1  downstream accepts record.
- out_sym  out  SYM_W  symbol of record.
- out_code  out  CODE_W  code, LSB-aligned; bit out_len-1 is the root-side bit.
- out_len  out  clog2(NSYM)+1  code length, 1..NSYM-1.
- out_mask  out  CODE_W  (1<<out_len)-1.
- out_last  out  1  high on record NSYM-1.
- busy  out  1  high in BUILD, ASSIGN and EMIT.

## Operation
- Node table: NODES entries, each holding weight, parent index, branch bit, active flag, code and length. Leaves occupy indices 0..NSYM-1; internal node k (k=0..NSYM-2) is index NSYM+k.
- LOAD: each in_valid&in_ready handshake writes leaf[cnt] = {sym, freq}, sets it active and increments cnt. The handshake at cnt=NSYM-1 moves to BUILD.
- BUILD, NSYM-1 cycles, merge k in cycle k:
  - Combinationally select among active nodes: min = lowest weight, ties to lowest index; second = lowest weight excluding min, same tie rule.
  - Create node NSYM+k with weight = sum; mark it active.
  - Set min.parent = second.parent = NSYM+k, min.bit = 0, second.bit = 1; clear both active flags.
  - Move to ASSIGN after merge NSYM-2.
- ASSIGN, 2*NSYM-2 cycles:
  - Root (index NODES-1) holds code 0, len 0.
  - Visit index i = NODES-2 down to 0, one per cycle: code[i] = (code[parent]<<1)|bit[i], len[i] = len[parent]+1.
  - Parent index > child index always, so the parent is resolved first.
  - Move to EMIT after i=0.
- EMIT:
  - Present leaf e = 0..NSYM-1 in load order.
  - Advance e on out_valid&out_ready.
  - Handshake with e=NSYM-1 (out_last=1) returns to LOAD with cnt=0.
- in_valid outside LOAD is ignored; in_ready stays 0.

## Timing
- Reset (asynchronous, reset=0):
  - state=LOAD, cnt=0, e=0, node table cleared.
  - in_ready=1, all other outputs 0.
- Reset mid-BUILD, ASSIGN or EMIT aborts the block immediately; no partial records are issued afterwards.
- Latency: call the edge that accepts the last load pair edge 0. out_valid rises after edge 3*NSYM-3; for NSYM=4 that is 9 edges.
- Throughput: one record per cycle while out_ready=1. Block period = NSYM load + 3*NSYM-3 + NSYM emit cycles minimum.
- Backpressure: while out_valid=1 and out_ready=0, every out_* stays stable.
- in_ready falls on the edge accepting pair NSYM-1 and rises the cycle after the last record handshake.
- Frequencies are zero-extended to W_W; sums are W_W bits.

## Test plan
- NSYM=4. Load A(0x41,f5), B(0x42,f1), C(0x43,f1), D(0x44,f2) -> records:
  - A code 1 len1 mask 001
  - B code 010 len3 mask 111
  - C code 011 len3 mask 111
  - D code 00 len2 mask 011, out_last=1
  - out_valid first high 9 cycles after the last load.
- NSYM=4, all freq=1, symbols 0..3 -> codes 00, 01, 10, 11, all len2; exercises the lowest-index tie rule.
- NSYM=2, freqs 3 and 0 -> symbol1 code 0 len1, symbol0 code 1 len1. The zero-frequency symbol is still coded.
- Backpressure: out_ready low for 5 cycles on record 1 -> record 1 held unchanged; records 0..3 each appear exactly once; in_ready=0 throughout.
- Assert reset low during ASSIGN -> outputs 0 and in_ready=1 immediately. A fresh 4-pair load then yields the correct codebook with no residue from the aborted block.
- in_valid held high during BUILD/EMIT with junk data -> ignored. Back-to-back blocks load correctly starting the cycle after out_last.

Source files
------------

// File: rtl/huff_encoder_n_if.sv
// Load and codebook handshake bundle for huff_encoder_n.
// The encoder connects through the slave modport; its driver and sink use master.
interface huff_encoder_n_if #(
  parameter int unsigned NSYM   = 4,
  parameter int unsigned SYM_W  = 8,
  parameter int unsigned FREQ_W = 4
);
  localparam int unsigned CODE_W = NSYM - 1;
  localparam int unsigned LEN_W  = $clog2(NSYM) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [SYM_W-1:0]  in_sym;
  logic [FREQ_W-1:0] in_freq;
  logic              out_valid;
  logic              out_ready;
  logic [SYM_W-1:0]  out_sym;
  logic [CODE_W-1:0] out_code;
  logic [LEN_W-1:0]  out_len;
  logic [CODE_W-1:0] out_mask;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid, in_sym, in_freq, out_ready,
    input  in_ready, out_valid, out_sym, out_code, out_len, out_mask, out_last, busy
  );

  modport slave (
    input  in_valid, in_sym, in_freq, out_ready,
    output in_ready, out_valid, out_sym, out_code, out_len, out_mask, out_last, busy
  );
endinterface

// File: rtl/huff_encoder_n.sv
// Huffman codebook generator: loads NSYM (symbol, frequency) pairs, merges one node per
// cycle, resolves codes root-down, then streams one record per symbol in load order.
module huff_encoder_n #(
  parameter int unsigned NSYM   = 4,
  parameter int unsigned SYM_W  = 8,
  parameter int unsigned FREQ_W = 4
) (
  input logic             clk,
  input logic             reset,
  huff_encoder_n_if.slave bus
);

  localparam int unsigned CODE_W = NSYM - 1;
  localparam int unsigned LEN_W  = $clog2(NSYM) + 1;
  localparam int unsigned W_W    = FREQ_W + $clog2(NSYM);
  localparam int unsigned NODES  = 2 * NSYM - 1;
  localparam int unsigned IDX_W  = $clog2(NODES);

  typedef enum logic [1:0] {StLoad, StBuild, StAssign, StEmit} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  logic [W_W-1:0]    weight_q [NODES];
  logic [IDX_W-1:0]  parent_q [NODES];
  logic [CODE_W-1:0] code_q   [NODES];
  logic [LEN_W-1:0]  len_q    [NODES];
  logic [SYM_W-1:0]  sym_q    [NODES];
  logic [NODES-1:0]  branch_q;
  logic [NODES-1:0]  active_q;

  logic              load_hs, emit_hs, last_sym;
  logic              min_found, sec_found;
  logic [IDX_W-1:0]  min_idx, sec_idx, new_idx, par_idx;
  logic [W_W-1:0]    min_w, sec_w, sum_w;

  assign load_hs  = (state_q == StLoad) && bus.in_valid;
  assign emit_hs  = (state_q == StEmit) && bus.out_ready;
  assign last_sym = (cnt_q == IDX_W'(NSYM - 1));
  assign new_idx  = IDX_W'(NSYM) + cnt_q;
  assign par_idx  = parent_q[cnt_q];
  assign sum_w    = min_w + sec_w;

  // Ascending scan with strict less-than gives ties to the lowest index.
  always_comb begin
    min_found = 1'b0;
    min_idx   = '0;
    min_w     = '0;
    sec_found = 1'b0;
    sec_idx   = '0;
    sec_w     = '0;
    for (int n = 0; n < NODES; n++) begin
      if (active_q[n] && (!min_found || weight_q[n] < min_w)) begin
        min_found = 1'b1;
        min_idx   = IDX_W'(n);
        min_w     = weight_q[n];
      end
    end
    for (int n = 0; n < NODES; n++) begin
      if (active_q[n] && (IDX_W'(n) != min_idx) && (!sec_found || weight_q[n] < sec_w)) begin
        sec_found = 1'b1;
        sec_idx   = IDX_W'(n);
        sec_w     = weight_q[n];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoad: begin
        if (load_hs) begin
          if (last_sym) begin
            state_d = StBuild;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StBuild: begin
        if (cnt_q == IDX_W'(NSYM - 2)) begin
          state_d = StAssign;
          cnt_d   = IDX_W'(NODES - 2);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAssign: begin
        if (cnt_q == '0) begin
          state_d = StEmit;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StEmit: begin
        if (emit_hs) begin
          if (last_sym) begin
            state_d = StLoad;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StLoad;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NODES; n++) begin
        weight_q[n] <= '0;
        parent_q[n] <= '0;
        code_q[n]   <= '0;
        len_q[n]    <= '0;
        sym_q[n]    <= '0;
      end
      branch_q <= '0;
      active_q <= '0;
    end else begin
      case (state_q)
        StLoad: begin
          if (load_hs) begin
            sym_q[cnt_q]    <= bus.in_sym;
            weight_q[cnt_q] <= W_W'(bus.in_freq);
            active_q[cnt_q] <= 1'b1;
          end
        end
        StBuild: begin
          // The newest node is the root after the final merge, so it starts at code 0, len 0.
          weight_q[new_idx] <= sum_w;
          code_q[new_idx]   <= '0;
          len_q[new_idx]    <= '0;
          active_q[new_idx] <= 1'b1;
          parent_q[min_idx] <= new_idx;
          parent_q[sec_idx] <= new_idx;
          branch_q[min_idx] <= 1'b0;
          branch_q[sec_idx] <= 1'b1;
          active_q[min_idx] <= 1'b0;
          active_q[sec_idx] <= 1'b0;
        end
        StAssign: begin
          code_q[cnt_q] <= (code_q[par_idx] << 1) | CODE_W'(branch_q[cnt_q]);
          len_q[cnt_q]  <= len_q[par_idx] + LEN_W'(1);
        end
        StEmit: begin
          // Drop the surviving root so the next block starts with a clean active set.
          if (emit_hs && last_sym) begin
            active_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  logic emit;
  assign emit = (state_q == StEmit);

  assign bus.in_ready  = (state_q == StLoad);
  assign bus.busy      = (state_q != StLoad);
  assign bus.out_valid = emit;
  assign bus.out_sym   = emit ? sym_q[cnt_q] : '0;
  assign bus.out_code  = emit ? code_q[cnt_q] : '0;
  assign bus.out_len   = emit ? len_q[cnt_q] : '0;
  assign bus.out_mask  = emit ? ~({CODE_W{1'b1}} << len_q[cnt_q]) : '0;
  assign bus.out_last  = emit && last_sym;

endmodule

// File: tb/tb_huff_encoder_n.sv
// Scoreboard bench for huff_encoder_n: NSYM=4 and NSYM=2 instances, directed codebooks.
module tb_huff_encoder_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huff_encoder_n_if #(.NSYM(4), .SYM_W(8), .FREQ_W(4)) bus4 ();
  huff_encoder_n_if #(.NSYM(2), .SYM_W(8), .FREQ_W(4)) bus2 ();

  huff_encoder_n #(.NSYM(4), .SYM_W(8), .FREQ_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  huff_encoder_n #(.NSYM(2), .SYM_W(8), .FREQ_W(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct packed {
    logic [7:0] sym;
    logic [7:0] code;
    logic [3:0] len;
    logic [7:0] mask;
    logic       last;
  } rec_t;

  rec_t exp4[$];
  rec_t exp2[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   load_cyc4 = 0;
  int   load_cyc2 = 0;
  bit   lat_arm4 = 1'b0;
  bit   lat_arm2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic rec_t mk(input logic [7:0] s, input logic [7:0] c, input logic [3:0] l,
                              input logic [7:0] m, input logic last);
    rec_t r;
    r.sym  = s;
    r.code = c;
    r.len  = l;
    r.mask = m;
    r.last = last;
    return r;
  endfunction

  // Monitor for the NSYM=4 instance.
  initial begin
    rec_t        r;
    logic        stall = 1'b0;
    logic        prev_valid = 1'b0;
    logic        after_last = 1'b0;
    logic [31:0] h_sym, h_code, h_len, h_mask, h_last;
    h_sym = '0; h_code = '0; h_len = '0; h_mask = '0; h_last = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        stall = 1'b0;
        prev_valid = 1'b0;
        after_last = 1'b0;
      end else begin
        if (after_last) begin
          check("in_ready_after_last", 32'(bus4.in_ready), 32'd1);
          after_last = 1'b0;
        end
        if (stall) begin
          check("hold_valid", 32'(bus4.out_valid), 32'd1);
          check("hold_sym", 32'(bus4.out_sym), h_sym);
          check("hold_code", 32'(bus4.out_code), h_code);
          check("hold_len", 32'(bus4.out_len), h_len);
          check("hold_mask", 32'(bus4.out_mask), h_mask);
          check("hold_last", 32'(bus4.out_last), h_last);
        end
        if (bus4.out_valid && !prev_valid && lat_arm4) begin
          check("latency4", 32'(cyc - load_cyc4), 32'd9);
          lat_arm4 = 1'b0;
        end
        if (bus4.out_valid) check("in_ready_low_emit", 32'(bus4.in_ready), 32'd0);
        if (bus4.out_valid && bus4.out_ready) begin
          if (exp4.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_record4 actual sym=0x%0h required no record", bus4.out_sym);
          end else begin
            r = exp4.pop_front();
            check("rec4_sym", 32'(bus4.out_sym), 32'(r.sym));
            check("rec4_code", 32'(bus4.out_code), 32'(r.code));
            check("rec4_len", 32'(bus4.out_len), 32'(r.len));
            check("rec4_mask", 32'(bus4.out_mask), 32'(r.mask));
            check("rec4_last", 32'(bus4.out_last), 32'(r.last));
            if (bus4.out_last) after_last = 1'b1;
          end
        end
        stall  = bus4.out_valid && !bus4.out_ready;
        h_sym  = 32'(bus4.out_sym);
        h_code = 32'(bus4.out_code);
        h_len  = 32'(bus4.out_len);
        h_mask = 32'(bus4.out_mask);
        h_last = 32'(bus4.out_last);
        prev_valid = bus4.out_valid;
      end
    end
  end

  // Monitor for the NSYM=2 instance.
  initial begin
    rec_t r;
    logic prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        prev_valid = 1'b0;
      end else begin
        if (bus2.out_valid && !prev_valid && lat_arm2) begin
          check("latency2", 32'(cyc - load_cyc2), 32'd3);
          lat_arm2 = 1'b0;
        end
        if (bus2.out_valid && bus2.out_ready) begin
          if (exp2.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_record2 actual sym=0x%0h required no record", bus2.out_sym);
          end else begin
            r = exp2.pop_front();
            check("rec2_sym", 32'(bus2.out_sym), 32'(r.sym));
            check("rec2_code", 32'(bus2.out_code), 32'(r.code));
            check("rec2_len", 32'(bus2.out_len), 32'(r.len));
            check("rec2_mask", 32'(bus2.out_mask), 32'(r.mask));
            check("rec2_last", 32'(bus2.out_last), 32'(r.last));
          end
        end
        prev_valid = bus2.out_valid;
      end
    end
  end

  task automatic load4(input logic [31:0] syms, input logic [15:0] freqs, input bit arm);
    int t;
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_sym   = syms[i*8 +: 8];
      bus4.in_freq  = freqs[i*4 +: 4];
      t = 0;
      while (bus4.in_ready !== 1'b1 && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (t == 100) begin
        checks++;
        failures++;
        $display("FAIL load4_timeout actual in_ready=0 required in_ready=1 for pair %0d", i);
      end
      @(posedge clk); #1;
    end
    load_cyc4 = cyc;
    lat_arm4 = arm;
    bus4.in_valid = 1'b0;
  endtask

  task automatic load2(input logic [15:0] syms, input logic [7:0] freqs);
    for (int i = 0; i < 2; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_sym   = syms[i*8 +: 8];
      bus2.in_freq  = freqs[i*4 +: 4];
      @(posedge clk); #1;
    end
    load_cyc2 = cyc;
    lat_arm2 = 1'b1;
    bus2.in_valid = 1'b0;
  endtask

  task automatic drain4();
    int t;
    t = 0;
    while (exp4.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 200) begin
      checks++;
      failures++;
      $display("FAIL drain4_timeout actual pending=%0d required pending=0", exp4.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic drain2();
    int t;
    t = 0;
    while (exp2.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 200) begin
      checks++;
      failures++;
      $display("FAIL drain2_timeout actual pending=%0d required pending=0", exp2.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic push_abcd();
    exp4.push_back(mk(8'h41, 8'b1,   4'd1, 8'b001, 1'b0));
    exp4.push_back(mk(8'h42, 8'b010, 4'd3, 8'b111, 1'b0));
    exp4.push_back(mk(8'h43, 8'b011, 4'd3, 8'b111, 1'b0));
    exp4.push_back(mk(8'h44, 8'b00,  4'd2, 8'b011, 1'b1));
  endtask

  task automatic push_tie();
    exp4.push_back(mk(8'h00, 8'b00, 4'd2, 8'b011, 1'b0));
    exp4.push_back(mk(8'h01, 8'b01, 4'd2, 8'b011, 1'b0));
    exp4.push_back(mk(8'h02, 8'b10, 4'd2, 8'b011, 1'b0));
    exp4.push_back(mk(8'h03, 8'b11, 4'd2, 8'b011, 1'b1));
  endtask

  localparam logic [31:0] SymAbcd  = {8'h44, 8'h43, 8'h42, 8'h41};
  localparam logic [15:0] FreqAbcd = {4'd2, 4'd1, 4'd1, 4'd5};
  localparam logic [31:0] SymTie   = {8'h03, 8'h02, 8'h01, 8'h00};
  localparam logic [15:0] FreqTie  = {4'd1, 4'd1, 4'd1, 4'd1};

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_sym = '0; bus4.in_freq = '0; bus4.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_sym = '0; bus2.in_freq = '0; bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_out_last", 32'(bus4.out_last), 32'd0);
    check("rst_out_sym", 32'(bus4.out_sym), 32'd0);
    check("rst_out_mask", 32'(bus4.out_mask), 32'd0);
    check("rst2_in_ready", 32'(bus2.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Reference codebook.
    push_abcd();
    load4(SymAbcd, FreqAbcd, 1'b1);
    drain4();

    // Equal weights resolve by lowest index.
    push_tie();
    load4(SymTie, FreqTie, 1'b1);
    drain4();

    // Stall record 1 for five cycles.
    push_abcd();
    load4(SymAbcd, FreqAbcd, 1'b1);
    t = 0;
    while (bus4.out_valid !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus4.out_ready = 1'b1;
    drain4();

    // Abort a block in ASSIGN, then a fresh load must be unaffected.
    load4(SymTie, FreqTie, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("busy_in_assign", 32'(bus4.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus4.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus4.in_ready), 32'd1);
    check("abort_busy", 32'(bus4.busy), 32'd0);
    check("abort_out_code", 32'(bus4.out_code), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    push_abcd();
    load4(SymAbcd, FreqAbcd, 1'b1);
    drain4();

    // Junk on the load port while busy, then a back-to-back block.
    push_tie();
    load4(SymTie, FreqTie, 1'b1);
    bus4.in_valid = 1'b1;
    bus4.in_sym   = 8'hEE;
    bus4.in_freq  = 4'hF;
    t = 0;
    while (bus4.out_valid !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    push_abcd();
    load4(SymAbcd, FreqAbcd, 1'b1);
    drain4();

    // Two symbols, one with zero frequency.
    exp2.push_back(mk(8'h30, 8'b1, 4'd1, 8'b1, 1'b0));
    exp2.push_back(mk(8'h31, 8'b0, 4'd1, 8'b1, 1'b1));
    load2({8'h31, 8'h30}, {4'd0, 4'd3});
    drain2();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
